ddr2_rb_read_ctrl: RTL and testbench

Controller that sequences one ddr2_ring_buffer8 instance for DDR2 read-data capture.
- Accepts a read-burst command and arms the buffer with a one-cycle listen pulse.
- Counts strobe edges until the burst has landed, then drains the captured words through readPtr to a valid/ready consumer.
- Tracks the buffer's internal write position so back-to-back partial bursts wrap correctly.

---
 rtl/ddr2_rb_pkg.sv | 13 +
 rtl/ddr2_strobe_edge_det.sv | 18 +
 rtl/ddr2_rb_read_ctrl.sv | 148 ++++++++++++++
 tb/tb_ddr2_rb_read_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_rb_pkg.sv
// Shared types and helpers for the DDR2 ring-buffer read/write-path controllers.
package ddr2_rb_pkg;
  localparam int RB_DEPTH = 8;
  localparam int PTR_W    = $clog2(RB_DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} rb_ctrl_state_t;
  typedef logic [1:0] blen_code_t;

  // Burst code 0..3 maps to 2,4,6,8 words.
  function automatic logic [3:0] blen_words(input blen_code_t code);
    return {1'b0, code, 1'b0} + 4'd2;
  endfunction
endpackage

// File: rtl/ddr2_strobe_edge_det.sv
// Strobe edge detector: registers the strobe history and flags any toggle.
module ddr2_strobe_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic edge_pulse
);
  logic strobe_q;
  logic strobe_d;

  assign strobe_d   = strobe;
  assign edge_pulse = strobe ^ strobe_q;

  always_ff @(posedge clk) begin
    if (reset) strobe_q <= 1'b0;
    else       strobe_q <= strobe_d;
  end
endmodule

// File: rtl/ddr2_rb_read_ctrl.sv
// Read-capture sequencer for one ddr2_ring_buffer8: arm, count strobe edges,
// then drain captured words via readPtr to a valid/ready consumer.
module ddr2_rb_read_ctrl
  import ddr2_rb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int DW          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_blen,
  output logic             rb_listen,
  input  logic             rb_strobe,
  output logic [PTR_W-1:0] rb_readPtr,
  input  logic [DW-1:0]    rb_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic             err_timeout,
  output logic             err_stray
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  rb_ctrl_state_t   state_q, state_d;
  logic [3:0]       nwords_q, nwords_d;
  logic [3:0]       ecnt_q, ecnt_d;
  logic [3:0]       widx_q, widx_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [PTR_W-1:0] wr_base_q, wr_base_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_stray_q, err_stray_d;
  logic             strobe_edge;
  logic             load;

  ddr2_strobe_edge_det u_edge (
    .clk       (clk),
    .reset     (reset),
    .strobe    (rb_strobe),
    .edge_pulse(strobe_edge)
  );

  assign cmd_ready   = (state_q == IDLE);
  assign rb_listen   = (state_q == ARM);
  assign rb_readPtr  = rd_ptr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign err_timeout = err_timeout_q;
  assign err_stray   = err_stray_q;

  always_comb begin
    state_d       = state_q;
    nwords_d      = nwords_q;
    ecnt_d        = ecnt_q;
    widx_d        = widx_q;
    tcnt_d        = tcnt_q;
    wr_base_d     = wr_base_q;
    rd_ptr_d      = rd_ptr_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    err_timeout_d = 1'b0;
    err_stray_d   = strobe_edge && (state_q != CAPTURE);
    load          = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          nwords_d = blen_words(cmd_blen);
          state_d  = ARM;
        end
      end
      ARM: begin
        ecnt_d  = '0;
        tcnt_d  = '0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        tcnt_d = tcnt_q + TW'(1);
        if (strobe_edge) ecnt_d = ecnt_q + 4'd1;
        if (strobe_edge && (ecnt_d == nwords_q)) begin
          rd_ptr_d = wr_base_q;
          widx_d   = '0;
          state_d  = DRAIN;
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          // The buffer has already advanced by every edge it saw; follow it.
          err_timeout_d = 1'b1;
          wr_base_d     = wr_base_q + ecnt_d[PTR_W-1:0];
          state_d       = IDLE;
        end
      end
      DRAIN: begin
        load = (widx_q != nwords_q) && (!out_valid_q || out_ready);
        if (load) begin
          out_data_d  = rb_dout;
          out_valid_d = 1'b1;
          out_last_d  = (widx_q == nwords_q - 4'd1);
          rd_ptr_d    = rd_ptr_q + PTR_W'(1);
          widx_d      = widx_q + 4'd1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
        if (out_valid_q && out_ready && out_last_q) begin
          wr_base_d = wr_base_q + nwords_q[PTR_W-1:0];
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      nwords_q      <= '0;
      ecnt_q        <= '0;
      widx_q        <= '0;
      tcnt_q        <= '0;
      wr_base_q     <= '0;
      rd_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_stray_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      nwords_q      <= nwords_d;
      ecnt_q        <= ecnt_d;
      widx_q        <= widx_d;
      tcnt_q        <= tcnt_d;
      wr_base_q     <= wr_base_d;
      rd_ptr_q      <= rd_ptr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      err_timeout_q <= err_timeout_d;
      err_stray_q   <= err_stray_d;
    end
  end
endmodule

// File: tb/tb_ddr2_rb_read_ctrl.sv
// Directed bench for ddr2_rb_read_ctrl with a behavioural 8-entry ring buffer.
module tb_ddr2_rb_read_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_blen;
  logic        rb_listen;
  logic        rb_strobe;
  logic [2:0]  rb_readPtr;
  logic [15:0] rb_dout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        err_timeout;
  logic        err_stray;

  int total = 0;
  int bad   = 0;

  // Ring buffer model: writes din on each strobe toggle while capture is enabled.
  logic [15:0] mem [8];
  logic [2:0]  wptr;
  logic        sprev;
  logic        cap_en;
  logic [15:0] din;
  logic [15:0] wq [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      wptr  <= 3'd0;
      sprev <= 1'b0;
    end else begin
      sprev <= rb_strobe;
      if (cap_en && (rb_strobe ^ sprev)) begin
        mem[wptr] <= din;
        wptr      <= wptr + 3'd1;
      end
    end
  end
  assign rb_dout = mem[rb_readPtr];

  ddr2_rb_read_ctrl #(.TIMEOUT_CYC(64), .DW(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_blen(cmd_blen), .rb_listen(rb_listen), .rb_strobe(rb_strobe),
    .rb_readPtr(rb_readPtr), .rb_dout(rb_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_timeout(err_timeout), .err_stray(err_stray)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] blen);
    @(negedge clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_blen  = blen;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("listen_on", {31'd0, rb_listen}, 32'd1);
    chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic send_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) chk("listen_one_cycle", {31'd0, rb_listen}, 32'd0);
      din       = wq[i];
      cap_en    = 1'b1;
      rb_strobe = ~rb_strobe;
    end
  endtask

  task automatic drain(input int n, input logic [2:0] start, input int stall);
    logic [2:0] p;
    @(negedge clk);
    cap_en = 1'b0;
    chk("drain_start_ptr", {29'd0, rb_readPtr}, {29'd0, start});
    chk("no_valid_at_entry", {31'd0, out_valid}, 32'd0);
    for (int w = 0; w < n; w++) begin
      @(negedge clk);
      p = start + 3'(w + 1);
      chk("word_valid", {31'd0, out_valid}, 32'd1);
      chk("word_data", {16'd0, out_data}, {16'd0, wq[w]});
      chk("word_last", {31'd0, out_last}, (w == n - 1) ? 32'd1 : 32'd0);
      chk("word_ptr", {29'd0, rb_readPtr}, {29'd0, p});
      if (w == stall) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_data", {16'd0, out_data}, {16'd0, wq[w]});
          chk("stall_ptr", {29'd0, rb_readPtr}, {29'd0, p});
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    chk("valid_drops", {31'd0, out_valid}, 32'd0);
    chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int  cyc;
    bit  saw_valid;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_blen  = 2'd0;
    rb_strobe = 1'b0;
    out_ready = 1'b1;
    cap_en    = 1'b0;
    din       = 16'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_listen", {31'd0, rb_listen}, 32'd0);
    chk("rst_ptr", {29'd0, rb_readPtr}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_errs", {30'd0, err_timeout, err_stray}, 32'd0);

    // Full 8-word burst from wr_base 0
    wq = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
    issue(2'd3); send_edges(8); drain(8, 3'd0, -1);
    $display("burst8 from ptr0 done");

    // Two 4-word bursts: second lands at ptr 4
    wq = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    issue(2'd1); send_edges(4); drain(4, 3'd0, -1);
    $display("burst4 from ptr0 done");
    wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    issue(2'd1); send_edges(4); drain(4, 3'd4, -1);
    $display("burst4 from ptr4 done");

    // Move wr_base to 6, then wrap 6,7,0,1
    wq = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
    issue(2'd2); send_edges(6); drain(6, 3'd0, -1);
    $display("burst6 from ptr0 done");
    wq = '{16'hE001, 16'hE002, 16'hE003, 16'hE004};
    issue(2'd1); send_edges(4); drain(4, 3'd6, -1);
    $display("burst4 wrap from ptr6 done");

    // Backpressure on word 2, wr_base now 2
    wq = '{16'h5A00, 16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04, 16'h5A05, 16'h5A06, 16'h5A07};
    issue(2'd3); send_edges(8); drain(8, 3'd2, 2);
    $display("burst8 with stall done");

    // Timeout: 3 of 4 edges; pulse at cycle 65 counted from the ARM cycle
    wq = '{16'hDEAD, 16'hBEEF, 16'hCAFE};
    issue(2'd1); send_edges(3);
    cyc = 3;
    saw_valid = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) saw_valid = 1'b1;
      if (err_timeout) break;
    end
    cap_en = 1'b0;
    chk("timeout_cycle", 32'(cyc), 32'd65);
    chk("timeout_no_output", {31'd0, saw_valid}, 32'd0);
    @(negedge clk);
    chk("timeout_one_pulse", {31'd0, err_timeout}, 32'd0);
    chk("timeout_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    $display("timeout after %0d cycles", cyc);

    // Stray edges in IDLE
    rb_strobe = ~rb_strobe;
    @(negedge clk);
    chk("stray_pulse1", {31'd0, err_stray}, 32'd1);
    @(negedge clk);
    chk("stray_clear", {31'd0, err_stray}, 32'd0);
    rb_strobe = ~rb_strobe;
    @(negedge clk);
    chk("stray_pulse2", {31'd0, err_stray}, 32'd1);
    $display("stray edges done");

    // wr_base must be 2+3=5 and unaffected by stray edges
    wq = '{16'h7E57, 16'hBEEF};
    issue(2'd0); send_edges(2); drain(2, 3'd5, -1);
    $display("burst2 from ptr5 done");

    // Reset in the middle of a drain
    wq = '{16'h9000, 16'h9001, 16'h9002, 16'h9003, 16'h9004, 16'h9005, 16'h9006, 16'h9007};
    issue(2'd3); send_edges(8);
    @(negedge clk);
    cap_en = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    reset     = 1'b1;
    rb_strobe = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ptr", {29'd0, rb_readPtr}, 32'd0);
    chk("midrst_data", {16'd0, out_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("postrst_errs", {30'd0, err_timeout, err_stray}, 32'd0);
    $display("mid-drain reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
